spi_master_nch: RTL and testbench

//  Parametrised SPI master for the top_spi subsystem. Generalises the fixed 8-bit master to

---
 rtl/spi_master_nch.sv | 228 ++++++++++++++++++++++
 tb/tb_spi_master_nch.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_nch.sv
// spi_master_nch
// Parametrised SPI master. It sends DATA_W-bit frames in any CPOL/CPHA mode,
// MSB or LSB first, with a programmable SCK half-period and NUM_SS active-low
// slave selects. Frames are requested through a valid/ready port. Received
// frames are reported with a one-cycle rx_valid strobe. An optional one-cycle
// interrupt pulse marks the end of each frame.
//
// Ports
//   clk, rst          system clock; asynchronous active-low reset
//   cfg_cpol          SCK idle level
//   cfg_cphase        0: sample on leading edge, 1: sample on trailing edge
//   cfg_lsbfe         1: LSB first, 0: MSB first
//   cfg_div           SCK half-period = cfg_div+1 clk cycles
//   cfg_ss_sel        index of slave select to assert (out of range: none)
//   cfg_irq_en        enable interupt_request pulse
//   tx_valid/tx_ready frame request handshake, tx_data frame to send
//   rx_valid/rx_data  received-frame strobe and held frame
//   busy              frame in progress (SETUP..DONE)
//   interupt_request  one-cycle pulse in DONE when enabled
//   sck, mosi, miso   serial bus
//   ss_n              active-low slave selects
module spi_master_nch #(
    parameter int DATA_W = 8,
    parameter int NUM_SS = 4,
    parameter int DIV_W  = 8,
    parameter int SS_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_cpol,
    input  logic              cfg_cphase,
    input  logic              cfg_lsbfe,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [SS_W-1:0]   cfg_ss_sel,
    input  logic              cfg_irq_en,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              interupt_request,
    output logic              sck,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_SS-1:0] ss_n
);

    localparam int TOG_W = $clog2(2 * DATA_W + 1);
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [TOG_W-1:0] TOG_MAX = TOG_W'(2 * DATA_W);
    localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(DATA_W);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        DONE
    } state_t;

    state_t state, next_state;

    // Configuration captured at accept so a frame is immune to cfg changes.
    logic              cpol_q;
    logic              cpha_q;
    logic              lsbfe_q;
    logic [DIV_W-1:0]  div_q;
    logic [SS_W-1:0]   sel_q;
    logic              irq_en_q;

    logic [DIV_W-1:0]  div_cnt;
    logic [TOG_W-1:0]  tog_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic [DATA_W-1:0] rx_data_q;
    logic              sck_q;
    logic              mosi_q;

    logic accept;
    logic hp_end;
    logic toggle_now;
    logic sample_edge;

    function automatic logic first_bit(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? v[0] : v[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_tx(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? (v >> 1) : (v << 1);
    endfunction

    function automatic logic [DATA_W-1:0] shift_rx(input logic [DATA_W-1:0] v, input logic lsb,
                                                   input logic b);
        return lsb ? {b, v[DATA_W-1:1]} : {v[DATA_W-2:0], b};
    endfunction

    assign accept = tx_valid & tx_ready;
    assign hp_end = (div_cnt == div_q);

    // An SCK toggle happens at the end of SETUP and at the end of every XFER
    // half-period except the last one, giving exactly 2*DATA_W toggles.
    assign toggle_now = hp_end && ((state == SETUP) ||
                                   ((state == XFER) && (tog_cnt != TOG_MAX)));

    // tog_cnt counts completed toggles, so an even count means the coming
    // toggle is a leading edge. CPHA=0 samples on leading, CPHA=1 on trailing.
    assign sample_edge = (~tog_cnt[0]) ^ cpha_q;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: each non-IDLE phase ends on a half-period boundary,
    // DONE always lasts a single cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = SETUP;
            SETUP:   if (hp_end) next_state = XFER;
            XFER:    if (hp_end && (tog_cnt == TOG_MAX)) next_state = HOLD;
            HOLD:    if (hp_end) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs decoded from state. The slave select is active for the whole
    // SETUP..HOLD window, which guarantees ss_n is high in DONE between frames.
    always_comb begin
        tx_ready         = (state == IDLE);
        busy             = (state != IDLE);
        rx_valid         = (state == DONE);
        interupt_request = (state == DONE) && irq_en_q;
        rx_data          = rx_data_q;
        sck              = sck_q;
        mosi             = mosi_q;
        ss_n             = '1;
        if ((state == SETUP) || (state == XFER) || (state == HOLD)) begin
            for (int i = 0; i < NUM_SS; i++) begin
                if (sel_q == SS_W'(i)) ss_n[i] = 1'b0;
            end
        end
    end

    // Datapath: configuration capture, half-period timer, SCK generation and
    // the TX/RX shift registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            lsbfe_q   <= 1'b0;
            div_q     <= '0;
            sel_q     <= '0;
            irq_en_q  <= 1'b0;
            div_cnt   <= '0;
            tog_cnt   <= '0;
            bit_cnt   <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            rx_data_q <= '0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    sck_q   <= cfg_cpol;
                    mosi_q  <= 1'b0;
                    div_cnt <= '0;
                    tog_cnt <= '0;
                    bit_cnt <= '0;
                    if (accept) begin
                        cpol_q   <= cfg_cpol;
                        cpha_q   <= cfg_cphase;
                        lsbfe_q  <= cfg_lsbfe;
                        div_q    <= cfg_div;
                        sel_q    <= cfg_ss_sel;
                        irq_en_q <= cfg_irq_en;
                        rx_sr    <= '0;
                        // CPHA=0 needs the first bit on the wire before the
                        // first (sampling) edge, so present it during SETUP.
                        if (!cfg_cphase) begin
                            mosi_q <= first_bit(tx_data, cfg_lsbfe);
                            tx_sr  <= shift_tx(tx_data, cfg_lsbfe);
                        end else begin
                            tx_sr  <= tx_data;
                        end
                    end
                end
                SETUP, XFER, HOLD: begin
                    div_cnt <= hp_end ? '0 : div_cnt + 1'b1;
                    if (toggle_now) begin
                        sck_q   <= ~sck_q;
                        tog_cnt <= tog_cnt + 1'b1;
                        if (sample_edge) begin
                            if (bit_cnt != BIT_MAX) begin
                                rx_sr   <= shift_rx(rx_sr, lsbfe_q, miso);
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            mosi_q <= first_bit(tx_sr, lsbfe_q);
                            tx_sr  <= shift_tx(tx_sr, lsbfe_q);
                        end
                    end
                    if ((state == HOLD) && hp_end) begin
                        rx_data_q <= rx_sr;
                        mosi_q    <= 1'b0;
                    end
                end
                DONE: begin
                    div_cnt <= '0;
                    sck_q   <= cpol_q;
                    mosi_q  <= 1'b0;
                end
                default: begin
                    div_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_nch.sv
// tb_spi_master_nch
// Scoreboard bench for spi_master_nch. Expected frames are pushed when a
// request is accepted and compared against rx_data when rx_valid fires.
// A behavioural SPI slave either loops mosi back or shifts out its own word,
// and it records the mosi bit sequence it sees.
module tb_spi_master_nch;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_cpol = 1'b0;
    logic       cfg_cphase = 1'b0;
    logic       cfg_lsbfe = 1'b0;
    logic [7:0] cfg_div = 8'd0;
    logic [2:0] cfg_ss_sel = 3'd0;
    logic       cfg_irq_en = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'd0;
    logic       tx_ready, rx_valid, busy, interupt_request, sck, mosi;
    logic [7:0] rx_data;
    logic [3:0] ss_n;

    logic loopback = 1'b1;
    logic miso_slv = 1'b0;
    wire  miso = loopback ? mosi : miso_slv;

    int checks = 0;
    int passes = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] exp_v, got_v;

    int         ss_low, ss_run_max, ss_gap_min, sck_rises, rise_first, rise_second;
    int         rx_pulses, rv_cycles, irq_pulses;
    logic [3:0] ss_and;
    bit         timed_out, send_to;

    // Slave model state.
    logic [7:0] slv_data = 8'h00;
    logic [7:0] slv_seq = 8'h00;
    bit         slv_cpha = 1'b0;
    bit         slv_lsb = 1'b0;
    int         slv_idx = 0;
    int         slv_edges = 0;
    logic       slv_busy_d = 1'b0;
    logic       slv_sck_d = 1'b0;

    spi_master_nch #(
        .DATA_W(8),
        .NUM_SS(4),
        .DIV_W (8),
        .SS_W  (3)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_cpol        (cfg_cpol),
        .cfg_cphase      (cfg_cphase),
        .cfg_lsbfe       (cfg_lsbfe),
        .cfg_div         (cfg_div),
        .cfg_ss_sel      (cfg_ss_sel),
        .cfg_irq_en      (cfg_irq_en),
        .tx_valid        (tx_valid),
        .tx_data         (tx_data),
        .tx_ready        (tx_ready),
        .rx_valid        (rx_valid),
        .rx_data         (rx_data),
        .busy            (busy),
        .interupt_request(interupt_request),
        .sck             (sck),
        .mosi            (mosi),
        .miso            (miso),
        .ss_n            (ss_n)
    );

    always #5 clk = ~clk;

    function automatic logic slv_bit(input int i);
        if (i > 7) return 1'b0;
        return slv_lsb ? slv_data[i] : slv_data[7-i];
    endfunction

    // Slave: restarts when busy rises, then reacts to every SCK edge.
    always @(sck or busy) begin
        if (busy && !slv_busy_d) begin
            slv_idx   = 0;
            slv_edges = 0;
            slv_seq   = 8'h00;
            miso_slv  = slv_cpha ? 1'b0 : slv_bit(0);
        end else if (busy && (sck !== slv_sck_d)) begin
            slv_edges++;
            if (((slv_edges % 2) == 1) != slv_cpha) begin
                slv_seq = {slv_seq[6:0], mosi};
                if (slv_cpha) slv_idx++;
            end else begin
                if (!slv_cpha) slv_idx++;
                miso_slv = slv_bit(slv_idx);
            end
        end
        slv_busy_d = busy;
        slv_sck_d  = sck;
    end

    task automatic set_cfg(input logic [7:0] div, input logic cpol, input logic cpha,
                           input logic lsb, input logic [2:0] sel, input logic irq);
        cfg_div    = div;
        cfg_cpol   = cpol;
        cfg_cphase = cpha;
        cfg_lsbfe  = lsb;
        cfg_ss_sel = sel;
        cfg_irq_en = irq;
        slv_cpha   = cpha;
        slv_lsb    = lsb;
    endtask

    // Raise tx_valid and wait for the accept edge; the frame's expected rx
    // value goes on the scoreboard at that point.
    task automatic applyStimulus(input logic [7:0] d, input logic [7:0] expect_rx);
        int w = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (!tx_ready && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (!tx_ready) send_to = 1'b1;
        else exp_q.push_back(expect_rx);
        @(posedge clk);
        #1;
    endtask

    // Collect bus statistics until `want` rx_valid pulses or the budget ends.
    task automatic watch(input int want, input int budget);
        int   cyc = 0;
        int   run = 0;
        int   gap = 0;
        bit   seen_run = 1'b0;
        logic prev_sck;
        logic prev_rv = 1'b0;
        ss_low = 0; ss_run_max = 0; ss_gap_min = 1000; sck_rises = 0;
        rise_first = 0; rise_second = 0; rx_pulses = 0; rv_cycles = 0; irq_pulses = 0;
        ss_and = 4'hF; timed_out = 1'b0;
        got_q.delete();
        prev_sck = sck;
        while (rx_pulses < want && cyc < budget + 3) begin
            @(negedge clk);
            cyc++;
            ss_and &= ss_n;
            if (ss_n != 4'hF) begin
                if (run == 0 && seen_run && gap < ss_gap_min) ss_gap_min = gap;
                run++;
                ss_low++;
                if (run > ss_run_max) ss_run_max = run;
                gap = 0;
            end else begin
                if (run > 0) seen_run = 1'b1;
                run = 0;
                gap++;
            end
            if (busy && sck && !prev_sck) begin
                sck_rises++;
                if (sck_rises == 1) rise_first = cyc;
                else if (sck_rises == 2) rise_second = cyc;
            end
            prev_sck = sck;
            if (rx_valid) rv_cycles++;
            if (interupt_request) irq_pulses++;
            if (rx_valid && !prev_rv) begin
                rx_pulses++;
                got_q.push_back(rx_data);
            end
            prev_rv = rx_valid;
        end
        if (rx_pulses < want) timed_out = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (rx_valid) rv_cycles++;
            if (interupt_request) irq_pulses++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (sck !== 1'b0) $display("[TB] FAIL rst_sck: got %b expected 0", sck); else passes++;
        checks++; if (mosi !== 1'b0) $display("[TB] FAIL rst_mosi: got %b expected 0", mosi); else passes++;
        checks++; if (ss_n !== 4'hF) $display("[TB] FAIL rst_ss_n: got %b expected 1111", ss_n); else passes++;
        checks++; if (tx_ready !== 1'b1) $display("[TB] FAIL rst_tx_ready: got %b expected 1", tx_ready); else passes++;
        checks++; if (rx_valid !== 1'b0) $display("[TB] FAIL rst_rx_valid: got %b expected 0", rx_valid); else passes++;
        checks++; if (rx_data !== 8'h00) $display("[TB] FAIL rst_rx_data: got %h expected 00", rx_data); else passes++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL rst_busy: got %b expected 0", busy); else passes++;
        checks++; if (interupt_request !== 1'b0) $display("[TB] FAIL rst_irq: got %b expected 0", interupt_request); else passes++;
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_mode0_loop();
        set_cfg(8'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
        loopback = 1'b1;
        send_to  = 1'b0;
        repeat (2) @(negedge clk);
        fork
            begin applyStimulus(8'hA5, 8'hA5); tx_valid = 1'b0; end
            watch(1, 200);
        join
        checks++; if (timed_out || send_to) $display("[TB] FAIL t1_timeout: got 1 expected 0"); else passes++;
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) $display("[TB] FAIL t1_rx_data: got none expected %h", exp_v);
            else begin got_v = got_q.pop_front(); if (got_v !== exp_v) $display("[TB] FAIL t1_rx_data: got %h expected %h", got_v, exp_v); else passes++; end
        end
        checks++; if (ss_run_max !== 18) $display("[TB] FAIL t1_ss_low: got %0d expected 18", ss_run_max); else passes++;
        checks++; if (ss_and !== 4'b1110) $display("[TB] FAIL t1_ss_n: got %b expected 1110", ss_and); else passes++;
        checks++; if (sck_rises !== 8) $display("[TB] FAIL t1_sck_rises: got %0d expected 8", sck_rises); else passes++;
        checks++; if (rv_cycles !== 1) $display("[TB] FAIL t1_rx_valid_pulse: got %0d expected 1", rv_cycles); else passes++;
        checks++; if (irq_pulses !== 1) $display("[TB] FAIL t1_irq: got %0d expected 1", irq_pulses); else passes++;
        checks++; if (slv_seq !== 8'hA5) $display("[TB] FAIL t1_mosi_bits: got %h expected a5", slv_seq); else passes++;
        checks++; if (mosi !== 1'b0) $display("[TB] FAIL t1_mosi_idle: got %b expected 0", mosi); else passes++;
    endtask

    task automatic test_mode3_slave();
        set_cfg(8'd3, 1'b1, 1'b1, 1'b1, 3'd0, 1'b1);
        loopback = 1'b0;
        slv_data = 8'h81;
        send_to  = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (sck !== 1'b1) $display("[TB] FAIL t2_sck_idle_pre: got %b expected 1", sck); else passes++;
        fork
            begin applyStimulus(8'h3C, 8'h81); tx_valid = 1'b0; end
            watch(1, 400);
        join
        checks++; if (timed_out || send_to) $display("[TB] FAIL t2_timeout: got 1 expected 0"); else passes++;
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) $display("[TB] FAIL t2_rx_data: got none expected %h", exp_v);
            else begin got_v = got_q.pop_front(); if (got_v !== exp_v) $display("[TB] FAIL t2_rx_data: got %h expected %h", got_v, exp_v); else passes++; end
        end
        // Bits seen on the wire in order 0,0,1,1,1,1,0,0.
        checks++; if (slv_seq !== 8'b0011_1100) $display("[TB] FAIL t2_mosi_bits: got %b expected 00111100", slv_seq); else passes++;
        checks++; if (rise_second - rise_first !== 8) $display("[TB] FAIL t2_sck_period: got %0d expected 8", rise_second - rise_first); else passes++;
        checks++; if (ss_run_max !== 72) $display("[TB] FAIL t2_ss_low: got %0d expected 72", ss_run_max); else passes++;
        checks++; if (sck !== 1'b1) $display("[TB] FAIL t2_sck_idle_post: got %b expected 1", sck); else passes++;
    endtask

    task automatic test_ss_select();
        set_cfg(8'd0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0);
        loopback = 1'b1;
        send_to  = 1'b0;
        repeat (2) @(negedge clk);
        fork
            begin applyStimulus(8'h5A, 8'h5A); tx_valid = 1'b0; end
            watch(1, 200);
        join
        checks++; if (timed_out || send_to) $display("[TB] FAIL t3_timeout_sel2: got 1 expected 0"); else passes++;
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) $display("[TB] FAIL t3_rx_data_sel2: got none expected %h", exp_v);
            else begin got_v = got_q.pop_front(); if (got_v !== exp_v) $display("[TB] FAIL t3_rx_data_sel2: got %h expected %h", got_v, exp_v); else passes++; end
        end
        checks++; if (ss_and !== 4'b1011) $display("[TB] FAIL t3_ss_n_sel2: got %b expected 1011", ss_and); else passes++;
        checks++; if (ss_low !== 18) $display("[TB] FAIL t3_ss_low_sel2: got %0d expected 18", ss_low); else passes++;

        cfg_ss_sel = 3'd5;
        fork
            begin applyStimulus(8'hC3, 8'hC3); tx_valid = 1'b0; end
            watch(1, 200);
        join
        checks++; if (timed_out || send_to) $display("[TB] FAIL t3_timeout_sel5: got 1 expected 0"); else passes++;
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) $display("[TB] FAIL t3_rx_data_sel5: got none expected %h", exp_v);
            else begin got_v = got_q.pop_front(); if (got_v !== exp_v) $display("[TB] FAIL t3_rx_data_sel5: got %h expected %h", got_v, exp_v); else passes++; end
        end
        checks++; if (ss_and !== 4'b1111) $display("[TB] FAIL t3_ss_n_sel5: got %b expected 1111", ss_and); else passes++;
    endtask

    task automatic test_cfg_midframe();
        set_cfg(8'd1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0);
        loopback = 1'b1;
        send_to  = 1'b0;
        repeat (2) @(negedge clk);
        fork
            begin
                applyStimulus(8'h96, 8'h96);
                tx_valid = 1'b0;
                repeat (10) @(negedge clk);
                cfg_div   = 8'd2;
                cfg_cpol  = 1'b1;
                cfg_lsbfe = 1'b1;
            end
            watch(1, 300);
        join
        checks++; if (timed_out || send_to) $display("[TB] FAIL t4_timeout_a: got 1 expected 0"); else passes++;
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) $display("[TB] FAIL t4_rx_data_a: got none expected %h", exp_v);
            else begin got_v = got_q.pop_front(); if (got_v !== exp_v) $display("[TB] FAIL t4_rx_data_a: got %h expected %h", got_v, exp_v); else passes++; end
        end
        checks++; if (ss_run_max !== 36) $display("[TB] FAIL t4_ss_low_a: got %0d expected 36", ss_run_max); else passes++;
        checks++; if (slv_seq !== 8'h96) $display("[TB] FAIL t4_mosi_bits_a: got %h expected 96", slv_seq); else passes++;

        slv_lsb = 1'b1;
        repeat (2) @(negedge clk);
        fork
            begin applyStimulus(8'h1E, 8'h1E); tx_valid = 1'b0; end
            watch(1, 300);
        join
        checks++; if (timed_out || send_to) $display("[TB] FAIL t4_timeout_b: got 1 expected 0"); else passes++;
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) $display("[TB] FAIL t4_rx_data_b: got none expected %h", exp_v);
            else begin got_v = got_q.pop_front(); if (got_v !== exp_v) $display("[TB] FAIL t4_rx_data_b: got %h expected %h", got_v, exp_v); else passes++; end
        end
        checks++; if (ss_run_max !== 54) $display("[TB] FAIL t4_ss_low_b: got %0d expected 54", ss_run_max); else passes++;
        checks++; if (slv_seq !== 8'h78) $display("[TB] FAIL t4_mosi_bits_b: got %h expected 78", slv_seq); else passes++;
        checks++; if (rise_second - rise_first !== 6) $display("[TB] FAIL t4_sck_period_b: got %0d expected 6", rise_second - rise_first); else passes++;
    endtask

    task automatic test_back_to_back();
        set_cfg(8'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        loopback = 1'b1;
        send_to  = 1'b0;
        repeat (3) @(negedge clk);
        fork
            begin
                applyStimulus(8'h12, 8'h12);
                applyStimulus(8'h34, 8'h34);
                tx_valid = 1'b0;
            end
            watch(2, 400);
        join
        checks++; if (timed_out || send_to) $display("[TB] FAIL t5_timeout: got 1 expected 0"); else passes++;
        checks++; if (rx_pulses !== 2) $display("[TB] FAIL t5_rx_pulses: got %0d expected 2", rx_pulses); else passes++;
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) $display("[TB] FAIL t5_rx_data: got none expected %h", exp_v);
            else begin got_v = got_q.pop_front(); if (got_v !== exp_v) $display("[TB] FAIL t5_rx_data: got %h expected %h", got_v, exp_v); else passes++; end
        end
        checks++; if (ss_gap_min < 1 || ss_gap_min > 4) $display("[TB] FAIL t5_ss_gap: got %0d expected 1..4", ss_gap_min); else passes++;
        checks++; if (irq_pulses !== 0) $display("[TB] FAIL t5_irq: got %0d expected 0", irq_pulses); else passes++;
        checks++; if (rv_cycles !== 2) $display("[TB] FAIL t5_rx_valid_cycles: got %0d expected 2", rv_cycles); else passes++;
    endtask

    task automatic test_reset_midframe();
        int rv_seen = 0;
        set_cfg(8'd1, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1);
        loopback = 1'b1;
        send_to  = 1'b0;
        repeat (2) @(negedge clk);
        applyStimulus(8'hE7, 8'hE7);
        tx_valid = 1'b0;
        repeat (16) @(negedge clk);
        checks++; if (busy !== 1'b1) $display("[TB] FAIL t6_busy_before: got %b expected 1", busy); else passes++;
        #2 rst = 1'b0;
        #1;
        checks++; if (ss_n !== 4'hF) $display("[TB] FAIL t6_ss_n: got %b expected 1111", ss_n); else passes++;
        checks++; if (sck !== 1'b0) $display("[TB] FAIL t6_sck: got %b expected 0", sck); else passes++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL t6_busy: got %b expected 0", busy); else passes++;
        repeat (4) begin
            @(negedge clk);
            if (rx_valid || interupt_request) rv_seen++;
        end
        checks++; if (rv_seen !== 0) $display("[TB] FAIL t6_no_rx_valid: got %0d expected 0", rv_seen); else passes++;
        exp_q.delete();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        fork
            begin applyStimulus(8'h4B, 8'h4B); tx_valid = 1'b0; end
            watch(1, 300);
        join
        checks++; if (timed_out || send_to) $display("[TB] FAIL t6_timeout: got 1 expected 0"); else passes++;
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) $display("[TB] FAIL t6_rx_data: got none expected %h", exp_v);
            else begin got_v = got_q.pop_front(); if (got_v !== exp_v) $display("[TB] FAIL t6_rx_data: got %h expected %h", got_v, exp_v); else passes++; end
        end
        checks++; if (ss_and !== 4'b0111) $display("[TB] FAIL t6_ss_n_after: got %b expected 0111", ss_and); else passes++;
        checks++; if (ss_run_max !== 36) $display("[TB] FAIL t6_ss_low_after: got %0d expected 36", ss_run_max); else passes++;
    endtask

    initial begin
        test_reset();
        test_mode0_loop();
        test_mode3_slave();
        test_ss_select();
        test_cfg_midframe();
        test_back_to_back();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
